// File: rtl/ram_responder_pkg.sv
// Shared types and constants for the RAM responder (memory end of the hello/ack bus).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ram_responder_pkg;

  localparam int RAM_ADDRSIZE = 8;
  localparam int RAM_DATASIZE = 8;

  typedef enum logic [1:0] {
    RAM_ST_IDLE = 2'd0,
    RAM_ST_WAIT = 2'd1,
    RAM_ST_ACK  = 2'd2
  } ram_state_e;

  // Wait-state counter width; a zero-latency build still gets a 1-bit counter.
  function automatic int cnt_width(input int lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous RAM, read-first, registered read data, no reset on storage.
// Latency: 1 cycle from enabled access to o_dout.
// Backpressure: none; every enabled cycle performs an access.
// Ports: i_clk, i_en (access strobe), i_we (write on access), i_addr, i_wdata, o_dout.
module ram_array
  import ram_responder_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDRSIZE,
  parameter int DATA_W = RAM_DATASIZE
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_dout
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_dout;

  // Old contents are captured before the write lands (read-first).
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_dout <= r_mem[i_addr];
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder of the hello/ack bus: accepts on hello, acks after LATENCY wait states.
// Latency: ack 1+LATENCY cycles after acceptance; one request per 2+LATENCY cycles.
// Backpressure: initiator holds hello until ack; dropping it early aborts and sets sticky o_proto_err.
// Ports: i_clk, i_rst (async, active-low), i_hello/i_addr/i_we/i_wdata request,
//        o_ack/o_rdata completion, o_busy (request in flight), o_proto_err (sticky abort flag).
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int ADDR_W  = RAM_ADDRSIZE,
  parameter int DATA_W  = RAM_DATASIZE,
  parameter int LATENCY = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hello,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_proto_err
);

  localparam int CNT_W = cnt_width(LATENCY);

  ram_state_e       r_state;
  ram_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_proto_err;
  logic             w_perr_set;
  logic             w_accept;
  logic [DATA_W-1:0] w_dout;

  // The array registers address/data and commits the write at the acceptance
  // edge, so no separate request latch is needed. Gating with i_rst keeps a
  // hello seen during reset from touching the store.
  assign w_accept = (r_state == RAM_ST_IDLE) && i_hello && i_rst;

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram_array (
    .i_clk   (i_clk),
    .i_en    (w_accept),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .o_dout  (w_dout)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= RAM_ST_IDLE;
      r_cnt       <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_proto_err <= r_proto_err | w_perr_set;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_perr_set  = 1'b0;
    case (r_state)
      RAM_ST_IDLE: begin
        if (i_hello) begin
          w_cnt_nxt   = CNT_W'(LATENCY);
          w_state_nxt = (LATENCY > 0) ? RAM_ST_WAIT : RAM_ST_ACK;
        end
      end
      RAM_ST_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        // An early hello drop wins even on the final wait edge: no ack is owed.
        if (!i_hello) begin
          w_state_nxt = RAM_ST_IDLE;
          w_perr_set  = 1'b1;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = RAM_ST_ACK;
        end
      end
      RAM_ST_ACK: begin
        // Always return to IDLE so a held hello is seen as a fresh request.
        w_state_nxt = RAM_ST_IDLE;
      end
      default: begin
        w_state_nxt = RAM_ST_IDLE;
      end
    endcase
  end

  assign o_ack       = (r_state == RAM_ST_ACK);
  assign o_busy      = (r_state == RAM_ST_WAIT) || (r_state == RAM_ST_ACK);
  assign o_rdata     = o_ack ? w_dout : '0;
  assign o_proto_err = r_proto_err;

endmodule
